uart_rx_os16: RTL

UART_RX_OS16 -- requirements
Module: uart_rx_os16

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_os16.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, baud enumeration, framing constants
// and the baud divisor function used by both receiver and transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned OVERSAMPLE   = 16;
    localparam int unsigned SAMPLE_FIRST = OVERSAMPLE / 2 - 1;
    localparam int unsigned SAMPLE_MID   = OVERSAMPLE / 2;
    localparam int unsigned SAMPLE_LAST  = OVERSAMPLE / 2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef enum logic [2:0] {
        BAUD_2400   = 3'd0,
        BAUD_4800   = 3'd1,
        BAUD_9600   = 3'd2,
        BAUD_19200  = 3'd3,
        BAUD_38400  = 3'd4,
        BAUD_57600  = 3'd5,
        BAUD_115200 = 3'd6,
        BAUD_230400 = 3'd7
    } baud_t;

    function automatic int unsigned baud_rate(input baud_t sel);
        int unsigned rate;
        case (sel)
            BAUD_2400:   rate = 2400;
            BAUD_4800:   rate = 4800;
            BAUD_9600:   rate = 9600;
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            BAUD_230400: rate = 230400;
            default:     rate = 115200;
        endcase
        return rate;
    endfunction

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input baud_t sel);
        int unsigned rate;
        rate = baud_rate(sel);
        return (clk_hz + (OVERSAMPLE / 2) * rate) / (OVERSAMPLE * rate);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every 'div' clocks, with a
// synchronous clear that restarts the period from zero.
module uart_baud_tick #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = !clear && (cnt == div - WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver, 8N1, majority vote of three mid-bit samples.
// Stop bit is judged at mid-bit so back-to-back frames are accepted.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic [2:0] baudset,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int DIV_W = $clog2(baud_div(CLK_HZ, BAUD_2400) + 1);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam int unsigned DIV_TABLE [8] = '{
        baud_div(CLK_HZ, BAUD_2400),
        baud_div(CLK_HZ, BAUD_4800),
        baud_div(CLK_HZ, BAUD_9600),
        baud_div(CLK_HZ, BAUD_19200),
        baud_div(CLK_HZ, BAUD_38400),
        baud_div(CLK_HZ, BAUD_57600),
        baud_div(CLK_HZ, BAUD_115200),
        baud_div(CLK_HZ, BAUD_230400)
    };

    logic [1:0]           sync_q;
    logic [1:0]           sync_ok;
    logic                 rxs;
    logic                 armed, armed_n;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     s_cnt, s_cnt_n;
    logic [BIT_W-1:0]     bit_idx, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [1:0]           samp, samp_n;
    baud_t                baud_q, baud_n;
    logic [7:0]           data_n;
    logic                 valid_n, ferr_n;
    logic                 div_clear;
    logic [DIV_W-1:0]     div_val;
    logic                 tick;
    logic                 maj;

    assign rxs     = sync_q[1];
    assign rx_busy = (state != IDLE);
    assign div_val = DIV_W'(DIV_TABLE[baud_q]);
    assign maj     = (samp[0] & samp[1]) | (rxs & (samp[0] | samp[1]));

    // sync_ok marks when rxs reflects a real line sample rather than the reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b11;
            sync_ok <= 2'b00;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            sync_ok <= {sync_ok[0], 1'b1};
        end
    end

    uart_baud_tick #(
        .WIDTH(DIV_W)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (div_clear),
        .div    (div_val),
        .tick   (tick)
    );

    // A start is only accepted once the line has been seen idle high since reset,
    // so a reset released in the middle of a low bit cannot start a bogus frame.
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        bit_n     = bit_idx;
        shift_n   = shift;
        samp_n    = samp;
        baud_n    = baud_q;
        armed_n   = armed;
        data_n    = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        div_clear = 1'b0;

        if (state != IDLE && tick) begin
            s_cnt_n = s_cnt + CNT_W'(1);
            if (s_cnt == CNT_W'(SAMPLE_FIRST)) samp_n[0] = rxs;
            if (s_cnt == CNT_W'(SAMPLE_MID))   samp_n[1] = rxs;
        end

        case (state)
            IDLE: begin
                div_clear = 1'b1;
                baud_n    = baud_t'(baudset);
                s_cnt_n   = '0;
                bit_n     = '0;
                if (sync_ok[1] && rxs) armed_n = 1'b1;
                if (armed && !rxs) state_n = START;
            end
            START: begin
                if (tick) begin
                    if (s_cnt == CNT_W'(SAMPLE_LAST) && maj) begin
                        state_n = IDLE;
                    end else if (s_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == CNT_W'(SAMPLE_LAST)) begin
                        shift_n = {maj, shift[DATA_BITS-1:1]};
                    end
                    if (s_cnt == CNT_W'(OVERSAMPLE - 1)) begin
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            bit_n   = '0;
                            state_n = STOP;
                        end else begin
                            bit_n = bit_idx + BIT_W'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (tick && s_cnt == CNT_W'(SAMPLE_LAST)) begin
                    if (maj) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            samp      <= 2'b00;
            baud_q    <= BAUD_2400;
            armed     <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            samp      <= samp_n;
            baud_q    <= baud_n;
            armed     <= armed_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
        end
    end

endmodule
